// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_pkg
// Brief   : Shared encodings and default widths for the ID/EX pipeline stage.
// Rev     : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

  localparam int C_WIDTH   = 32;
  localparam int C_RA_W    = 5;
  localparam int C_SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_SRL = 3'b011,
    ALU_SLL = 3'b100,
    ALU_OR  = 3'b101,
    ALU_AND = 3'b110
  } aluop_e;

  typedef enum logic {
    SRC_A_RS = 1'b0,
    SRC_A_RT = 1'b1
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RT    = 2'b00,
    SRC_B_IMM   = 2'b01,
    SRC_B_SHAMT = 2'b10,
    SRC_B_ZERO  = 2'b11
  } src_b_e;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : fwd_mux
// Brief   : Resolves EX/MEM then MEM/WB forwarding for one latched source.
// Rev     : 1.0  initial release
// ============================================================================
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int RA_W  = C_RA_W
) (
  input  logic [RA_W-1:0]  addr,
  input  logic [WIDTH-1:0] value,
  input  logic             exmem_RegWrite,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_RegWrite,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] fwd_value
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // Register 0 is hardwired, so a writer targeting it never forwards.
  assign w_exmem_hit = exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == addr);
  assign w_memwb_hit = memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == addr);

  always_comb begin
    fwd_value = value;
    if (w_exmem_hit) begin
      fwd_value = exmem_result;
    end else if (w_memwb_hit) begin
      fwd_value = memwb_result;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with operand forwarding and load-use stall.
// Rev     : 1.0  initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int RA_W  = C_RA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [WIDTH-1:0]     imm,
  input  logic [C_SHAMT_W-1:0] shamt,
  input  logic [RA_W-1:0]      rs_addr,
  input  logic [RA_W-1:0]      rt_addr,
  input  logic [RA_W-1:0]      rd_addr,
  input  logic                 src_a_sel,
  input  logic [1:0]           src_b_sel,
  input  logic [2:0]           ALUOp_in,
  input  logic                 RegWrite_in,
  input  logic                 MemRead_in,
  input  logic                 flush,
  input  logic                 exmem_RegWrite,
  input  logic [RA_W-1:0]      exmem_rd,
  input  logic [WIDTH-1:0]     exmem_result,
  input  logic                 memwb_RegWrite,
  input  logic [RA_W-1:0]      memwb_rd,
  input  logic [WIDTH-1:0]     memwb_result,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [2:0]           ALUOp,
  output logic                 out_valid,
  output logic                 out_RegWrite,
  output logic                 out_MemRead,
  output logic [RA_W-1:0]      out_rd,
  output logic                 hazard_stall
);

  logic                 r_valid;
  logic                 r_regwrite;
  logic                 r_memread;
  logic [RA_W-1:0]      r_rd;
  logic [RA_W-1:0]      r_rs_addr;
  logic [RA_W-1:0]      r_rt_addr;
  logic [WIDTH-1:0]     r_rs_data;
  logic [WIDTH-1:0]     r_rt_data;
  logic [WIDTH-1:0]     r_imm;
  logic [C_SHAMT_W-1:0] r_shamt;
  src_a_e               r_src_a_sel;
  src_b_e               r_src_b_sel;
  logic [2:0]           r_aluop;

  logic                 w_hazard_stall;
  logic                 w_bubble;
  logic [WIDTH-1:0]     w_fwd_rs;
  logic [WIDTH-1:0]     w_fwd_rt;
  logic [WIDTH-1:0]     w_shamt_ext;

  // A load in this stage cannot forward its data in time to a dependent consumer.
  assign w_hazard_stall = r_valid && r_memread && (r_rd != '0) && in_valid &&
                          ((rs_addr == r_rd) || (rt_addr == r_rd));
  assign w_bubble       = flush || w_hazard_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_rd        <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_src_a_sel <= SRC_A_RS;
      r_src_b_sel <= SRC_B_RT;
      r_aluop     <= ALU_ADD;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else begin
      r_valid     <= in_valid;
      r_regwrite  <= in_valid && RegWrite_in;
      r_memread   <= in_valid && MemRead_in;
      r_rd        <= rd_addr;
      r_rs_addr   <= rs_addr;
      r_rt_addr   <= rt_addr;
      r_rs_data   <= rs_data;
      r_rt_data   <= rt_data;
      r_imm       <= imm;
      r_shamt     <= shamt;
      r_src_a_sel <= src_a_e'(src_a_sel);
      r_src_b_sel <= src_b_e'(src_b_sel);
      r_aluop     <= ALUOp_in;
    end
  end

  fwd_mux #(
    .WIDTH (WIDTH),
    .RA_W  (RA_W)
  ) u_fwd_rs (
    .addr           (r_rs_addr),
    .value          (r_rs_data),
    .exmem_RegWrite (exmem_RegWrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_RegWrite (memwb_RegWrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_value      (w_fwd_rs)
  );

  fwd_mux #(
    .WIDTH (WIDTH),
    .RA_W  (RA_W)
  ) u_fwd_rt (
    .addr           (r_rt_addr),
    .value          (r_rt_data),
    .exmem_RegWrite (exmem_RegWrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_RegWrite (memwb_RegWrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_value      (w_fwd_rt)
  );

  assign w_shamt_ext = {{(WIDTH-C_SHAMT_W){1'b0}}, r_shamt};

  always_comb begin
    A = w_fwd_rs;
    if (r_src_a_sel == SRC_A_RT) begin
      A = w_fwd_rt;
    end
  end

  always_comb begin
    B = '0;
    case (r_src_b_sel)
      SRC_B_RT:    B = w_fwd_rt;
      SRC_B_IMM:   B = r_imm;
      SRC_B_SHAMT: B = w_shamt_ext;
      default:     B = '0;
    endcase
  end

  assign ALUOp        = r_aluop;
  assign out_valid    = r_valid;
  assign out_RegWrite = r_regwrite;
  assign out_MemRead  = r_memread;
  assign out_rd       = r_rd;
  assign hazard_stall = w_hazard_stall;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and the ALU. It latches decoded operands and control on each clock edge and resolves EX/MEM and MEM/WB forwarding on its outputs. It drives the ALU's A, B and ALUOp directly, and generates load-use stall and bubble insertion for the front end.

## Interface
Parameters:
- WIDTH, 32, datapath width
- RA_W, 5, register address width

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  reset, active-high, asynchronous
- in_valid  in  1  decode slot holds a real instruction
- rs_data, rt_data  in  WIDTH  register file read data
- imm  in  WIDTH  immediate, already sign-extended by decode
- shamt  in  5  shift amount field
- rs_addr, rt_addr, rd_addr  in  RA_W  source and destination register numbers
- src_a_sel  in  1  A source: 0 = rs, 1 = rt (shifts)
- src_b_sel  in  2  B source: 00 = rt, 01 = imm, 10 = zero-extended shamt, 11 = 0
- ALUOp_in  in  3  ALU operation code, passed through
- RegWrite_in, MemRead_in  in  1  decoded control
- flush  in  1  kill the instruction being captured (branch taken)
- exmem_RegWrite  in  1  EX/MEM writer valid
- exmem_rd  in  RA_W  EX/MEM destination register
- exmem_result  in  WIDTH  EX/MEM result
- memwb_RegWrite  in  1  MEM/WB writer valid
- memwb_rd  in  RA_W  MEM/WB destination register
- memwb_result  in  WIDTH  MEM/WB result
- A, B  out  WIDTH  ALU operands
- ALUOp  out  3  ALU operation code
- out_valid, out_RegWrite, out_MemRead  out  1  registered control, qualified by out_valid
- out_rd  out  RA_W  registered destination register
- hazard_stall  out  1  front end must hold PC and IF/ID this cycle

## Operation
- Reset: all registers clear. out_valid, out_RegWrite, out_MemRead = 0; ALUOp = 000; out_rd = 0. A and B are 0 because no forwarding can match register 0.
- Load-use detect (combinational): hazard_stall = out_valid & out_MemRead & out_rd≠0 & in_valid & (rs_addr==out_rd | rt_addr==out_rd).
- Per-edge update, in priority order:
  - flush = 1 or hazard_stall = 1: capture a bubble. out_valid, out_RegWrite and out_MemRead are cleared; the data fields don't matter.
  - Otherwise: capture all inputs. out_valid = in_valid, and RegWrite/MemRead are gated by in_valid.
- Forwarding on the latched rs and rt values (combinational), applied separately to each source:
  - EX/MEM match (exmem_RegWrite & exmem_rd≠0 & exmem_rd==addr) selects exmem_result.
  - Otherwise a MEM/WB match selects memwb_result.
  - Otherwise the latched register value is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand select after forwarding:
  - A = fwd_rs or fwd_rt, per src_a_sel.
  - B = fwd_rt, imm, {27'b0, shamt} or 0, per src_b_sel.
- When out_valid = 0, A, B and ALUOp still drive their latched values; downstream ignores them through out_RegWrite = 0.

## Timing
- Capture to A/B/ALUOp: 1 cycle, valid just after the CLK edge.
- Forwarding path (exmem_*/memwb_* to A/B) is purely combinational and adds the same-cycle delay of one 3:1 mux plus a 4:1 mux.
- hazard_stall is combinational from registered state and the decode inputs. Asserting it inserts exactly one bubble, because the load leaves the stage on the next edge.
- flush and hazard_stall in the same cycle produce one bubble; flush wins and is not double-counted.
- RST asserted mid-operation clears the stage immediately, without waiting for CLK. The first edge after RST deasserts captures normally.

## Structure
- Shared package holds:
  - ALUOp encodings (ADD 000, SUB 001, SLT 010, SRL 011, SLL 100, OR 101, AND 110).
  - src_a_sel / src_b_sel encodings.
  - WIDTH / RA_W defaults.
- One sub-module, fwd_mux: it takes the latched address and value plus both writer tuples and returns the forwarded value. It is instantiated twice, for rs and rt.

## Test plan
- Reset: assert RST mid-stream with out_valid = 1. Required: out_valid = 0, ALUOp = 000, A = B = 0 immediately, before any CLK edge.
- Plain capture: rs_data = 5, rt_data = 3, src_b_sel = 00, ALUOp_in = 001, in_valid = 1. Required: next cycle A = 5, B = 3, ALUOp = 001, out_valid = 1.
- Forward priority:
  - Latched rs_addr = 8, with exmem_rd = 8 (result 0xAAAA) and memwb_rd = 8 (result 0x5555), both writers valid. Required: A = 0xAAAA.
  - Drop exmem_RegWrite. Required: A = 0x5555.
  - With rs_addr = 0 and both writers targeting 0. Required: A = latched rs_data.
- Load-use: stage holds MemRead, out_rd = 4; decode presents rt_addr = 4. Required: hazard_stall = 1, then next cycle out_valid = 0. The following cycle, the re-presented instruction is captured with out_valid = 1.
- Shift and immediate select:
  - src_a_sel = 1, src_b_sel = 10, shamt = 7, rt_data = 0x1. Required: A = 0x1, B = 7.
  - src_b_sel = 01, imm = 0xFFFFFFFC. Required: B = 0xFFFFFFFC.
- Flush plus stall in the same cycle. Required: exactly one bubble (out_valid = 0 for one cycle), and hazard_stall deasserts the following cycle.
